// File: rtl/cla_seq_wide_adder_pkg.sv
// Shared types and helpers for the sequential wide-operand CLA adder.
package cla_seq_wide_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } cla_seq_state_t;

    // Chunk index width; a single-chunk build still needs a 1-bit index.
    function automatic int idx_width(input int chunks);
        int w;
        w = $clog2(chunks);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Parameterised combinational carry-lookahead adder slice.
module carry_lookahead_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;
    logic             c_acc;
    logic             p_chain;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // Each carry is a flat sum of generate terms gated by the propagate chain above them.
    always_comb begin
        // NOTE: every variable gets a default before any conditional or loop so no latch is inferred.
        carry    = '0;
        c_acc    = 1'b0;
        p_chain  = 1'b1;
        carry[0] = cin_i;
        for (int i = 0; i < WIDTH; i++) begin
            c_acc   = 1'b0;
            p_chain = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c_acc   = c_acc | (gen[j] & p_chain);
                p_chain = p_chain & prop[j];
            end
            carry[i+1] = c_acc | (p_chain & cin_i);
        end
    end

    assign sum_o  = prop ^ carry[WIDTH-1:0];
    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/cla_seq_wide_adder.sv
// Sequential wide adder: feeds one WIDTH-bit chunk per cycle, LSB first, through
// a single CLA slice with a registered inter-chunk carry, and reassembles the sum.
module cla_seq_wide_adder
    import cla_seq_wide_adder_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*CHUNKS-1:0] in_a,
    input  logic [WIDTH*CHUNKS-1:0] in_b,
    input  logic                    in_cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*CHUNKS-1:0] out_sum,
    output logic                    out_cout,
    output logic                    out_ovf,
    output logic                    busy
);

    localparam int N     = WIDTH * CHUNKS;
    localparam int IDX_W = idx_width(CHUNKS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHUNKS - 1);

    cla_seq_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     sum_q, sum_d;

    logic [WIDTH-1:0] slice_a;
    logic [WIDTH-1:0] slice_b;
    logic [WIDTH-1:0] slice_sum;
    logic             slice_cout;
    logic             in_hs;

    // In DONE a new operand set may enter in the same cycle the result leaves.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ADD);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
    assign out_ovf   = (a_q[N-1] & b_q[N-1] & ~sum_q[N-1]) |
                       (~a_q[N-1] & ~b_q[N-1] & sum_q[N-1]);

    assign slice_a = a_q[idx_q*WIDTH +: WIDTH];
    assign slice_b = b_q[idx_q*WIDTH +: WIDTH];

    carry_lookahead_adder #(
        .WIDTH (WIDTH)
    ) u_cla (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // Next-state and datapath update for the IDLE/ADD/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;

        unique case (state_q)
            IDLE: ;
            ADD: begin
                sum_d[idx_q*WIDTH +: WIDTH] = slice_sum;
                carry_d                     = slice_cout;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An accepted operand set overrides the plain return to IDLE.
        if (in_hs) begin
            state_d = ADD;
            idx_d   = '0;
            carry_d = in_cin;
            a_d     = in_a;
            b_d     = in_b;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

endmodule
